// File: rtl/mem_pkg.sv
// Definitions shared by the UART-loaded data memory and the CPU datapath:
// FSM encoding, default widths and the bytes-per-word helper.
package mem_pkg;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned ADDR_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int unsigned bpw(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/uart_word_assembler.sv
// Packs a little-endian UART byte stream into DATA_W-bit words; word_valid is
// asserted combinationally together with the last byte of each word.
module uart_word_assembler
   import mem_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              word_valid,
   output logic [DATA_W-1:0] word
);

   localparam int unsigned BPW   = bpw(DATA_W);
   localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

   logic [IDX_W-1:0] idx_q, idx_d;

   assign word_valid = byte_valid && (idx_q == LAST_IDX);

   always_comb begin
      idx_d = idx_q;
      if (byte_valid) begin
         idx_d = word_valid ? '0 : idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

   if (BPW > 1) begin : g_multi
      localparam int unsigned SH_W = (BPW - 1) * 8;

      logic [SH_W-1:0] shreg_q, shreg_d;

      // Shift right so the first byte of a word ends up in the lowest lane.
      always_comb begin
         shreg_d = shreg_q;
         if (byte_valid) begin
            shreg_d[SH_W-8 +: 8] = byte_data;
            for (int unsigned i = 0; i + 2 < BPW; i++) begin
               shreg_d[i*8 +: 8] = shreg_q[(i+1)*8 +: 8];
            end
         end
      end

      always_ff @(posedge clk) begin
         shreg_q <= shreg_d;
      end

      assign word = {byte_data, shreg_q};
   end else begin : g_single
      assign word = byte_data;
   end

endmodule

// File: rtl/uart_loaded_data_mem.sv
// CPU data memory with a UART byte-stream loader that fills an auto-incrementing
// address window; the CPU is stalled while the loader owns the array.
module uart_loaded_data_mem
   import mem_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter bit          INIT_IDX = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic [ADDR_W:0]   load_len,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              load_busy,
   output logic              load_done,
   output logic              cpu_stall,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]  words_left_q, words_left_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   logic              byte_fire;
   logic              word_valid;
   logic [DATA_W-1:0] word;

   assign byte_fire = rx_valid && rx_ready;

   uart_word_assembler #(
      .DATA_W (DATA_W)
   ) u_asm (
      .clk        (clk),
      .reset      (reset),
      .byte_valid (byte_fire),
      .byte_data  (rx_data),
      .word_valid (word_valid),
      .word       (word)
   );

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (load_start) begin
               state_d = (load_len == '0) ? DONE : RECV;
            end
         end
         RECV: begin
            if (word_valid && (words_left_q == CNT_W'(1))) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      rx_ready  = (state_q == RECV);
      load_busy = (state_q == RECV);
      load_done = (state_q == DONE);
   end

   assign cpu_stall = load_busy;

   // CPU writes are dropped in RECV so the loader has exclusive write access.
   always_comb begin
      ptr_d        = ptr_q;
      words_left_d = words_left_q;
      mem_d        = mem_q;
      unique case (state_q)
         IDLE: begin
            if (we) begin
               mem_d[addr] = wdata;
            end
            if (load_start) begin
               ptr_d        = load_base;
               words_left_d = load_len;
            end
         end
         RECV: begin
            if (word_valid) begin
               mem_d[ptr_q] = word;
               ptr_d        = ptr_q + ADDR_W'(1);
               words_left_d = words_left_q - CNT_W'(1);
            end
         end
         DONE: begin
            if (we) begin
               mem_d[addr] = wdata;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q        <= '0;
         words_left_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= INIT_IDX ? DATA_W'(i) : '0;
         end
      end else begin
         ptr_q        <= ptr_d;
         words_left_q <= words_left_d;
         mem_q        <= mem_d;
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: tb/tb_uart_loaded_data_mem.sv
// Directed bench for uart_loaded_data_mem: a reference copy of the array feeds a
// queue of expected read values that are popped and checked against rdata.
module tb_uart_loaded_data_mem;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_start;
   logic [3:0]  load_base;
   logic [4:0]  load_len;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        load_busy;
   logic        load_done;
   logic        cpu_stall;
   logic        we;
   logic [3:0]  addr;
   logic [15:0] wdata;
   logic [15:0] rdata;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] model [16];
   logic [15:0] exp_q [$];

   always #5 clk = ~clk;

   uart_loaded_data_mem #(
      .DATA_W   (16),
      .ADDR_W   (4),
      .INIT_IDX (1'b1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .load_start (load_start),
      .load_base  (load_base),
      .load_len   (load_len),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .load_busy  (load_busy),
      .load_done  (load_done),
      .cpu_stall  (cpu_stall),
      .we         (we),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) model[i] = 16'(i);
   endtask

   task automatic rd(input logic [3:0] a, input string tag);
      addr = a;
      exp_q.push_back(model[a]);
      #1;
      chk($sformatf("%s[%0d]", tag, a), {16'h0, rdata}, {16'h0, exp_q.pop_front()});
   endtask

   task automatic rd_all(input string tag);
      for (int i = 0; i < 16; i++) rd(4'(i), tag);
   endtask

   task automatic flags(input string tag, input logic rdy, input logic busy, input logic done);
      chk({tag, "_rx_ready"}, {31'h0, rx_ready}, {31'h0, rdy});
      chk({tag, "_busy"},     {31'h0, load_busy}, {31'h0, busy});
      chk({tag, "_done"},     {31'h0, load_done}, {31'h0, done});
      chk({tag, "_stall"},    {31'h0, cpu_stall}, {31'h0, busy});
   endtask

   task automatic start_load(input logic [3:0] base, input logic [4:0] len);
      load_start = 1'b1;
      load_base  = base;
      load_len   = len;
      tick();
      load_start = 1'b0;
   endtask

   // Idle for gap cycles, then present the byte until the loader takes it.
   task automatic send(input logic [7:0] b, input int gap, input logic last);
      int budget;
      rx_valid = 1'b0;
      repeat (gap) begin
         tick();
         chk("gap_busy", {31'h0, load_busy}, 32'h1);
      end
      rx_valid = 1'b1;
      rx_data  = b;
      budget   = 0;
      while (!rx_ready && budget < 20) begin
         tick();
         budget++;
      end
      chk("rx_ready_wait", {31'h0, rx_ready}, 32'h1);
      tick();
      rx_valid = 1'b0;
      chk("done_after_byte", {31'h0, load_done}, {31'h0, last});
   endtask

   initial begin
      reset      = 1'b1;
      load_start = 1'b0;
      load_base  = '0;
      load_len   = '0;
      rx_valid   = 1'b0;
      rx_data    = '0;
      we         = 1'b0;
      addr       = '0;
      wdata      = '0;
      model_reset();
      tick();
      tick();
      reset = 1'b0;
      #1;

      // Reset image and idle outputs
      flags("reset", 1'b0, 1'b0, 1'b0);
      rd_all("reset_mem");

      // CPU write
      we = 1'b1; addr = 4'd3; wdata = 16'hBEEF;
      tick();
      we = 1'b0;
      model[3] = 16'hBEEF;
      rd_all("cpu_wr");

      // Wrapping load: base 14, len 3
      start_load(4'd14, 5'd3);
      flags("recv", 1'b1, 1'b1, 1'b0);
      send(8'h11, 2, 1'b0);
      send(8'h22, 0, 1'b0);
      model[14] = 16'h2211;
      rd(4'd14, "word_visible");
      send(8'h33, 3, 1'b0);
      send(8'h44, 1, 1'b0);
      model[15] = 16'h4433;
      send(8'h55, 0, 1'b0);
      send(8'h66, 2, 1'b1);
      model[0] = 16'h6655;
      flags("load_end", 1'b0, 1'b0, 1'b1);
      tick();
      flags("post_done", 1'b0, 1'b0, 1'b0);
      rd_all("wrap_load");

      // len 0 with coincident CPU write, then a CPU write during DONE
      we = 1'b1; addr = 4'd6; wdata = 16'h6666;
      start_load(4'd9, 5'd0);
      model[6] = 16'h6666;
      addr = 4'd7; wdata = 16'h7777;
      flags("len0", 1'b0, 1'b0, 1'b1);
      tick();
      we = 1'b0;
      model[7] = 16'h7777;
      flags("len0_after", 1'b0, 1'b0, 1'b0);
      rd_all("len0_mem");

      // CPU write during RECV is dropped
      start_load(4'd8, 5'd1);
      we = 1'b1; addr = 4'd5; wdata = 16'h1234;
      #1;
      chk("stall_in_recv", {31'h0, cpu_stall}, 32'h1);
      tick();
      we = 1'b0;
      rd(4'd5, "dropped_wr");
      send(8'hC3, 0, 1'b0);
      send(8'hA5, 1, 1'b1);
      model[8] = 16'hA5C3;
      tick();
      rd_all("recv_we_mem");

      // Reset aborts a half-received word
      start_load(4'd2, 5'd1);
      send(8'h11, 0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      model_reset();
      flags("abort", 1'b0, 1'b0, 1'b0);
      rd(4'd2, "abort_mem");
      start_load(4'd2, 5'd1);
      send(8'hAA, 1, 1'b0);
      send(8'hBB, 0, 1'b1);
      model[2] = 16'hBBAA;
      tick();
      rd_all("reload");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
